// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding ICache block request at a time,
// unpacks each 8-byte response into up to two instruction slots.
module fetch_unit #(
  parameter int          IF_WIDTH = 2,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        icache_req_valid_o,
  output logic [31:0] icache_req_addr_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_resp_valid_i,
  input  logic [63:0] icache_resp_data_i,
  output logic        instr_valid_o [IF_WIDTH],
  output logic [31:0] instr_pc_o    [IF_WIDTH],
  output logic [31:0] instr_o       [IF_WIDTH],
  output logic [1:0]  dbg_state_o
);

  // Request handshake: a request transfers on any rising edge where
  // icache_req_valid_o and icache_req_ready_i are both 1; once valid is raised,
  // valid and addr hold until that edge unless flush_i or stall_i intervene.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] block_addr;
  logic        handshake;
  logic        deliver;
  logic        unused_bits;

  assign block_addr  = {pc_q[31:3], 3'b000};
  assign handshake   = icache_req_valid_o & icache_req_ready_i;
  assign deliver     = (state_q == S_WAIT) & icache_resp_valid_i & ~flush_i;
  assign unused_bits = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (handshake) state_d = flush_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        // A response arriving with a flush is simply dropped; no new stale request.
        if (icache_resp_valid_i) state_d = S_REQ;
        else if (flush_i)        state_d = S_DROP;
      end
      S_DROP: begin
        if (icache_resp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    icache_req_valid_o = (state_q == S_REQ) & ~stall_i;
    icache_req_addr_o  = block_addr;
    dbg_state_o        = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (flush_i) begin
      pc_q <= {redirect_pc_i[31:2], 2'b00};
    end else if (deliver) begin
      pc_q <= block_addr + 32'd8;
    end
  end

  // Slot outputs are zero except for the single cycle after a delivered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_o[0] <= 1'b0;
      instr_pc_o[0]    <= 32'd0;
      instr_o[0]       <= 32'd0;
      instr_valid_o[1] <= 1'b0;
      instr_pc_o[1]    <= 32'd0;
      instr_o[1]       <= 32'd0;
    end else begin
      instr_valid_o[0] <= deliver;
      instr_pc_o[0]    <= deliver ? pc_q : 32'd0;
      instr_o[0]       <= !deliver ? 32'd0 :
                          (pc_q[2] ? icache_resp_data_i[63:32] : icache_resp_data_i[31:0]);
      instr_valid_o[1] <= deliver & ~pc_q[2];
      instr_pc_o[1]    <= (deliver & ~pc_q[2]) ? pc_q + 32'd4 : 32'd0;
      instr_o[1]       <= (deliver & ~pc_q[2]) ? icache_resp_data_i[63:32] : 32'd0;
    end
  end

endmodule
